// File: rtl/stream_source.sv
// stream_source: buffers pixel vectors from a valid/ready producer in a FIFO and replays them
// as a raster-timed stream over a W_WIDTH x W_HEIGHT frame with a WIDTH x HEIGHT active region.
// Optional: define STREAM_SOURCE_BLANK_HOLD_EN to hold the last active pixel during blanking.
module stream_source #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned HEIGHT     = 48,
    parameter int unsigned W_WIDTH    = 80,
    parameter int unsigned W_HEIGHT   = 52,
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned UNITS      = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PREFILL    = 8,
    localparam int unsigned DW = BIT_WIDTH * UNITS,
    localparam int unsigned VW = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1,
    localparam int unsigned HW = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1
) (
    input  logic          clock,
    input  logic          n_rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_pixels,
    output logic          out_enable,
    output logic [DW-1:0] out_pixels,
    output logic [VW-1:0] out_vcnt,
    output logic [HW-1:0] out_hcnt,
    output logic          busy,
    output logic          underflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [VW-1:0] VLast    = VW'(W_HEIGHT - 1);
    localparam logic [HW-1:0] HLast    = HW'(W_WIDTH - 1);
    localparam logic [VW:0]   HeightX  = (VW + 1)'(HEIGHT);
    localparam logic [HW:0]   WidthX   = (HW + 1)'(WIDTH);
    localparam logic [CW-1:0] PrefillC = CW'(PREFILL);
    localparam logic [CW-1:0] DepthC   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StPrefill, StRun} state_e;

    state_e        state_q;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic          in_ready_q;
    logic          out_enable_q;
    logic [DW-1:0] out_pixels_q;
    logic [VW-1:0] vcnt_q, nv;
    logic [HW-1:0] hcnt_q, nh;
    logic          busy_q;
    logic          underflow_q;

    logic          push, pop, load, active, at_end, fifo_empty;
    logic [DW-1:0] head, blank_px;

    assign head       = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);

    // Next raster coordinate, whether it is loaded this edge, and the resulting FIFO handshake.
    always_comb begin
        push   = in_valid && in_ready_q;
        at_end = (vcnt_q == VLast) && (hcnt_q == HLast);
        load   = 1'b0;
        nv     = '0;
        nh     = '0;
        case (state_q)
            StPrefill: load = (count_q >= PrefillC);
            StRun: begin
                if (at_end) begin
                    // Back-to-back frame only if start is held at the last coordinate.
                    load = start;
                end else begin
                    load = 1'b1;
                    if (hcnt_q == HLast) begin
                        nv = vcnt_q + 1'b1;
                    end else begin
                        nv = vcnt_q;
                        nh = hcnt_q + 1'b1;
                    end
                end
            end
            default: load = 1'b0;
        endcase
        active  = ({1'b0, nv} < HeightX) && ({1'b0, nh} < WidthX);
        pop     = load && active && !fifo_empty;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            in_ready_q <= (count_d != DepthC);
        end
    end

    // FIFO storage; contents are don't-care once the pointers reset.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_pixels;
    end

`ifdef STREAM_SOURCE_BLANK_HOLD_EN
    logic [DW-1:0] last_q;

    // Remember the last real pixel popped this run; cleared whenever idle.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            last_q <= '0;
        end else if (state_q == StIdle) begin
            last_q <= '0;
        end else if (pop) begin
            last_q <= head;
        end
    end

    assign blank_px = last_q;
`else
    assign blank_px = '0;
`endif

    // Control FSM with registered stream outputs.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            underflow_q  <= 1'b0;
            out_enable_q <= 1'b0;
            out_pixels_q <= '0;
            vcnt_q       <= '0;
            hcnt_q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q     <= StPrefill;
                        busy_q      <= 1'b1;
                        underflow_q <= 1'b0;
                    end
                end
                StPrefill: begin
                    if (load) state_q <= StRun;
                end
                StRun: begin
                    if (!load) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (load) begin
                out_enable_q <= 1'b1;
                vcnt_q       <= nv;
                hcnt_q       <= nh;
                if (!active) begin
                    out_pixels_q <= blank_px;
                end else if (!fifo_empty) begin
                    out_pixels_q <= head;
                end else begin
                    // Timing never stalls: emit zero and flag it.
                    out_pixels_q <= '0;
                    underflow_q  <= 1'b1;
                end
            end else begin
                out_enable_q <= 1'b0;
                out_pixels_q <= '0;
                vcnt_q       <= '0;
                hcnt_q       <= '0;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_enable = out_enable_q;
    assign out_pixels = out_pixels_q;
    assign out_vcnt   = vcnt_q;
    assign out_hcnt   = hcnt_q;
    assign busy       = busy_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_stream_source.sv
// Directed bench for stream_source with a 6x3 frame, 4x2 active region, 8-deep FIFO, prefill 4.
module tb_stream_source;

    logic       clock;
    logic       n_rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixels;
    logic       out_enable;
    logic [7:0] out_pixels;
    logic [1:0] out_vcnt;
    logic [2:0] out_hcnt;
    logic       busy;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus / expectation state.
    int         feed_limit;
    int         pushed;
    int         pushed_prev;
    int         exp_next;
    logic [7:0] last_px;
    bit         uf_exp;

    stream_source #(
        .WIDTH     (4),
        .HEIGHT    (2),
        .W_WIDTH   (6),
        .W_HEIGHT  (3),
        .BIT_WIDTH (8),
        .UNITS     (1),
        .FIFO_DEPTH(8),
        .PREFILL   (4)
    ) dut (
        .clock     (clock),
        .n_rst     (n_rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixels (in_pixels),
        .out_enable(out_enable),
        .out_pixels(out_pixels),
        .out_vcnt  (out_vcnt),
        .out_hcnt  (out_hcnt),
        .busy      (busy),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: offer the next sequential pixel while below feed_limit, sample 1 after the edge.
    task automatic step();
        bit acc;
        if (pushed < feed_limit) begin
            in_valid  = 1'b1;
            in_pixels = 8'(pushed + 1);
        end else begin
            in_valid  = 1'b0;
        end
        acc = in_valid && in_ready;
        pushed_prev = pushed;
        @(posedge clock);
        #1;
        if (acc) pushed++;
    endtask

    task automatic end_check();
        check("idle_enable", out_enable, 0);
        check("idle_busy", busy, 0);
        check("idle_vcnt", out_vcnt, 0);
        check("idle_hcnt", out_hcnt, 0);
        check("idle_pixels", out_pixels, 0);
    endtask

    // Check ncyc raster cycles; pulse selects starting from idle vs. continuing a running frame.
    task automatic run_frame(input int ncyc, input bit pulse, input bit hold);
        int v;
        int h;
        logic [7:0] exp_px;
        if (pulse) begin
            start = 1'b1;
            step();
            if (!hold) start = 1'b0;
            uf_exp  = 1'b0;
            last_px = '0;
            for (int i = 0; i < 10 && !out_enable; i++) step();
        end
        check("run_enable", out_enable, 1);
        for (int c = 0; c < ncyc; c++) begin
            v = c / 6;
            h = c % 6;
            if (v < 2 && h < 4) begin
                if (exp_next <= pushed_prev) begin
                    exp_px  = 8'(exp_next);
                    last_px = exp_px;
                    exp_next++;
                end else begin
                    exp_px = '0;
                    uf_exp = 1'b1;
                end
            end else begin
`ifdef STREAM_SOURCE_BLANK_HOLD_EN
                exp_px = last_px;
`else
                exp_px = '0;
`endif
            end
            check("frm_enable", out_enable, 1);
            check("frm_busy", busy, 1);
            check("frm_vcnt", out_vcnt, v);
            check("frm_hcnt", out_hcnt, h);
            check("frm_pixels", out_pixels, exp_px);
            check("frm_underflow", underflow, uf_exp);
            step();
        end
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixels = '0;
        feed_limit = 0; pushed = 0; pushed_prev = 0; exp_next = 1; last_px = '0; uf_exp = 1'b0;

        // Reset state.
        #2;
        check("rst_ready", in_ready, 0);
        check("rst_underflow", underflow, 0);
        end_check();
        @(posedge clock); @(posedge clock); #1;
        n_rst = 1'b1;
        check("rel_ready_before", in_ready, 0);
        step();
        check("rel_ready_after", in_ready, 1);

        // 1: full prefill of 8, one frame, no underflow.
        feed_limit = 8;
        for (int i = 0; i < 8; i++) step();
        run_frame(18, 1, 0);
        end_check();
        check("t1_underflow", underflow, 0);

        // 2: only 5 pixels, underflow from (1,1) and sticky afterwards.
        feed_limit = pushed + 5;
        for (int i = 0; i < 5; i++) step();
        run_frame(18, 1, 0);
        end_check();
        check("t2_uf_sticky", underflow, 1);

        // 3: start held, two back-to-back frames with 16 pixels streamed.
        feed_limit = pushed + 8;
        for (int i = 0; i < 8; i++) step();
        feed_limit = pushed + 8;
        run_frame(18, 1, 1);
        start = 1'b0;
        run_frame(18, 0, 0);
        end_check();
        check("t3_underflow", underflow, 0);

        // 4: fill to full, extra pixel refused until the first pop frees a slot.
        feed_limit = pushed + 8;
        for (int i = 0; i < 8; i++) begin
            check("t4_fill_ready", in_ready, 1);
            step();
        end
        check("t4_full_ready", in_ready, 0);
        feed_limit = pushed + 1;
        step();
        step();
        check("t4_still_full", in_ready, 0);
        check("t4_busy", busy, 0);
        run_frame(18, 1, 0);
        end_check();
        check("t4_leftover_ready", in_ready, 1);

        // 5: leftover carries over; reset mid-frame at (1,2).
        feed_limit = pushed + 3;
        for (int i = 0; i < 3; i++) step();
        run_frame(8, 1, 0);
        check("t5_at_v", out_vcnt, 1);
        check("t5_at_h", out_hcnt, 2);
        check("t5_uf_before", underflow, 1);
        n_rst = 1'b0;
        #1;
        end_check();
        check("t5_rst_ready", in_ready, 0);
        check("t5_rst_uf", underflow, 0);
        pushed = 0; pushed_prev = 0; exp_next = 1; feed_limit = 0; last_px = '0; uf_exp = 1'b0;
        @(posedge clock); #1;
        n_rst = 1'b1;
        step();
        check("t5_rel_ready", in_ready, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_prefill_busy", busy, 1);
            check("t5_prefill_en", out_enable, 0);
        end
        feed_limit = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_partial_en", out_enable, 0);
        end
        feed_limit = 4;
        run_frame(18, 1, 0);
        end_check();
        check("t5_final_uf", underflow, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
